// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: active-low segment patterns,
// converter state encoding and the decimal-limit helper used for overflow.
package seg7_pkg;

   // Segment order {a,b,c,d,e,f,g}, a = MSB, 0 = segment lit.
   localparam logic [6:0] SEG_DIGIT [0:9] = '{
      7'b0000001,
      7'b1001111,
      7'b0010010,
      7'b0000110,
      7'b1001100,
      7'b0100100,
      7'b0100000,
      7'b0001111,
      7'b0000000,
      7'b0000100
   };

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b1111110;

   typedef enum logic [1:0] {
      CONV_IDLE  = 2'd0,
      CONV_SHIFT = 2'd1,
      CONV_DONE  = 2'd2
   } conv_state_t;

   function automatic logic [63:0] pow10(input int n);
      logic [63:0] p;
      p = 64'd1;
      for (int i = 0; i < n; i++) begin
         p = p * 64'd10;
      end
      return p;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one bit per cycle, with the overflow
// compare taken against the value captured at start.
module bin2bcd_seq
   import seg7_pkg::*;
#(
   parameter int DATA_W     = 10,
   parameter int NUM_DIGITS = 4
) (
   input  logic                    clk_d,
   input  logic                    reset,
   input  logic                    start,
   input  logic [DATA_W-1:0]       value,
   output conv_state_t             state,
   output logic [4*NUM_DIGITS-1:0] bcd,
   output logic                    ovf
);

   localparam int          BCD_W = 4 * NUM_DIGITS;
   localparam int          CNT_W = $clog2(DATA_W + 1);
   localparam logic [63:0] LIMIT = pow10(NUM_DIGITS);

   conv_state_t              state_nxt;
   logic [DATA_W-1:0]        bin;
   logic [DATA_W-1:0]        bin_nxt;
   logic [BCD_W-1:0]         bcd_nxt;
   logic [BCD_W-1:0]         adj;
   logic [BCD_W+DATA_W-1:0]  shifted;
   logic [CNT_W-1:0]         cnt;
   logic [CNT_W-1:0]         cnt_nxt;
   logic                     ovf_nxt;

   always_ff @(posedge clk_d) begin
      if (reset) begin
         state <= CONV_IDLE;
         bin   <= '0;
         bcd   <= '0;
         cnt   <= '0;
         ovf   <= 1'b0;
      end else begin
         state <= state_nxt;
         bin   <= bin_nxt;
         bcd   <= bcd_nxt;
         cnt   <= cnt_nxt;
         ovf   <= ovf_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      bin_nxt   = bin;
      bcd_nxt   = bcd;
      cnt_nxt   = cnt;
      ovf_nxt   = ovf;
      adj       = bcd;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (bcd[4*i +: 4] >= 4'd5) begin
            adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
         end
      end
      shifted = {adj, bin} << 1;

      case (state)
         CONV_IDLE: begin
            if (start) begin
               state_nxt = CONV_SHIFT;
               bin_nxt   = value;
               bcd_nxt   = '0;
               cnt_nxt   = '0;
               ovf_nxt   = (64'(value) >= LIMIT);
            end
         end
         CONV_SHIFT: begin
            {bcd_nxt, bin_nxt} = shifted;
            cnt_nxt            = cnt + 1'b1;
            if (cnt == CNT_W'(DATA_W - 1)) begin
               state_nxt = CONV_DONE;
            end
         end
         CONV_DONE: begin
            state_nxt = CONV_IDLE;
         end
         default: begin
            state_nxt = CONV_IDLE;
         end
      endcase
   end

endmodule

// File: rtl/seg7_bcd_scan_driver.sv
// Multiplexed 7-segment driver: picks frequency or current, converts to BCD
// once per idle frame, and scans NUM_DIGITS active-low digits.
module seg7_bcd_scan_driver
   import seg7_pkg::*;
#(
   parameter int DATA_W     = 10,
   parameter int NUM_DIGITS = 4,
   parameter int SCAN_DIV   = 1
) (
   input  logic                  clk_d,
   input  logic                  reset,
   input  logic [DATA_W-1:0]     frecuencia,
   input  logic [DATA_W-1:0]     corriente,
   input  logic                  control,
   input  logic                  blank_lz,
   output logic [6:0]            codificacion,
   output logic [NUM_DIGITS-1:0] digito,
   output logic                  conv_done
);

   localparam int BCD_W = 4 * NUM_DIGITS;
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   logic [PRE_W-1:0]  pre;
   logic [IDX_W-1:0]  idx;
   logic              pre_top;
   logic              frame_start;
   logic [DATA_W-1:0] src;

   conv_state_t       conv_state;
   logic [BCD_W-1:0]  conv_bcd;
   logic              conv_ovf;

   logic [BCD_W-1:0]  latch;
   logic              latch_ovf;
   logic [BCD_W-1:0]  disp_bcd;
   logic              disp_ovf;

   logic [3:0]        nib;
   logic              upper_zero;
   logic [6:0]        seg_nxt;

   assign pre_top     = (pre == PRE_W'(SCAN_DIV - 1));
   assign frame_start = (idx == '0) && (pre == '0);
   assign src         = control ? frecuencia : corriente;

   bin2bcd_seq #(
      .DATA_W     (DATA_W),
      .NUM_DIGITS (NUM_DIGITS)
   ) u_conv (
      .clk_d (clk_d),
      .reset (reset),
      .start (frame_start),
      .value (src),
      .state (conv_state),
      .bcd   (conv_bcd),
      .ovf   (conv_ovf)
   );

   assign conv_done = (conv_state == CONV_DONE);

   // Bypass the latch during DONE so the new digits are on the pins the very next cycle.
   assign disp_bcd = conv_done ? conv_bcd : latch;
   assign disp_ovf = conv_done ? conv_ovf : latch_ovf;

   always_ff @(posedge clk_d) begin
      if (reset) begin
         pre <= '0;
         idx <= '0;
      end else if (pre_top) begin
         pre <= '0;
         idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
      end else begin
         pre <= pre + 1'b1;
      end
   end

   always_ff @(posedge clk_d) begin
      if (reset) begin
         latch     <= '0;
         latch_ovf <= 1'b0;
      end else if (conv_done) begin
         latch     <= conv_bcd;
         latch_ovf <= conv_ovf;
      end
   end

   always_comb begin
      nib        = disp_bcd[{idx, 2'b00} +: 4];
      upper_zero = ((disp_bcd >> {idx, 2'b00}) == '0);
      seg_nxt    = SEG_BLANK;
      if (disp_ovf) begin
         seg_nxt = SEG_DASH;
      end else if (blank_lz && (idx != '0) && upper_zero) begin
         seg_nxt = SEG_BLANK;
      end else if (nib <= 4'd9) begin
         seg_nxt = SEG_DIGIT[nib];
      end
   end

   always_ff @(posedge clk_d) begin
      if (reset) begin
         codificacion <= SEG_BLANK;
         digito       <= '1;
      end else begin
         codificacion <= seg_nxt;
         digito       <= ~(NUM_DIGITS'(1) << idx);
      end
   end

endmodule

// File: tb/tb_seg7_bcd_scan_driver.sv
// Bench for seg7_bcd_scan_driver: three parameterisations driven from one clock,
// expected digit patterns come from a decimal reference model.
module tb_seg7_bcd_scan_driver;

   logic        clk_d = 1'b0;
   logic        reset = 1'b1;
   logic        control = 1'b0;
   logic        blank_lz = 1'b0;
   logic [9:0]  frecuencia = '0;
   logic [9:0]  corriente = '0;
   logic [13:0] frecuencia_w = '0;
   logic [13:0] corriente_w = '0;

   logic [6:0]  seg_a, seg_w, seg_s;
   logic [3:0]  dig_a, dig_w;
   logic [7:0]  dig_s;
   logic        done_a, done_w, done_s;

   int          vectors = 0;
   int          miscompares = 0;
   logic [6:0]  exp_q[$];
   logic [7:0]  exp_dig_q[$];
   logic [6:0]  obs_seg_arr [8];

   always #5 clk_d = ~clk_d;

   seg7_bcd_scan_driver u_dut (
      .clk_d(clk_d), .reset(reset), .frecuencia(frecuencia), .corriente(corriente),
      .control(control), .blank_lz(blank_lz), .codificacion(seg_a), .digito(dig_a),
      .conv_done(done_a)
   );

   seg7_bcd_scan_driver #(.DATA_W(14)) u_wide (
      .clk_d(clk_d), .reset(reset), .frecuencia(frecuencia_w), .corriente(corriente_w),
      .control(control), .blank_lz(blank_lz), .codificacion(seg_w), .digito(dig_w),
      .conv_done(done_w)
   );

   seg7_bcd_scan_driver #(.NUM_DIGITS(8), .SCAN_DIV(3)) u_scan (
      .clk_d(clk_d), .reset(reset), .frecuencia(frecuencia), .corriente(corriente),
      .control(control), .blank_lz(blank_lz), .codificacion(seg_s), .digito(dig_s),
      .conv_done(done_s)
   );

   function automatic int unsigned p10(input int n);
      int unsigned p = 1;
      for (int i = 0; i < n; i++) p = p * 10;
      return p;
   endfunction

   function automatic logic [6:0] ref_seg(input int unsigned v, input int k, input int nd, input bit blank);
      int unsigned d;
      if (v >= p10(nd)) return 7'b1111110;
      if (blank && k > 0 && v < p10(k)) return 7'b1111111;
      d = (v / p10(k)) % 10;
      case (d)
         0: return 7'b0000001;
         1: return 7'b1001111;
         2: return 7'b0010010;
         3: return 7'b0000110;
         4: return 7'b1001100;
         5: return 7'b0100100;
         6: return 7'b0100000;
         7: return 7'b0001111;
         8: return 7'b0000000;
         9: return 7'b0000100;
         default: return 7'b1111111;
      endcase
   endfunction

   function automatic logic [7:0] obs_dig(input int w);
      case (w)
         0: return {4'hF, dig_a};
         1: return {4'hF, dig_w};
         default: return dig_s;
      endcase
   endfunction

   function automatic logic [6:0] obs_seg(input int w);
      case (w)
         0: return seg_a;
         1: return seg_w;
         default: return seg_s;
      endcase
   endfunction

   function automatic logic obs_done(input int w);
      case (w)
         0: return done_a;
         1: return done_w;
         default: return done_s;
      endcase
   endfunction

   task automatic push_frame(input int unsigned v, input int nd, input bit blank);
      for (int k = 0; k < nd; k++) exp_q.push_back(ref_seg(v, k, nd, blank));
   endtask

   // Waits for the next conv_done pulse; an expired budget counts as a miscompare.
   task automatic wait_done(input int w, input int budget, output int cyc);
      logic got;
      cyc = 0;
      got = 1'b0;
      while (!got && cyc < budget) begin
         @(posedge clk_d); #1;
         cyc++;
         got = obs_done(w);
      end
      vectors++;
      if (!got) begin
         miscompares++;
         $display("FAIL wait_done inst%0d: no conv_done within %0d cycles", w, budget);
      end
   endtask

   // Records the segment pattern seen on each digit over nd consecutive cycles.
   task automatic capture(input int w, input int nd);
      logic [7:0] d;
      for (int k = 0; k < 8; k++) obs_seg_arr[k] = 7'bx;
      repeat (nd) begin
         @(posedge clk_d); #1;
         d = obs_dig(w);
         for (int k = 0; k < nd; k++) begin
            if (d == ~(8'h01 << k)) obs_seg_arr[k] = obs_seg(w);
         end
      end
   endtask

   task automatic test_reset();
      int cyc;
      logic [6:0] e;
      control = 1'b0; corriente = 10'd30; blank_lz = 1'b0;
      reset = 1'b1;
      repeat (3) @(posedge clk_d);
      #1;
      for (int w = 0; w < 3; w++) begin
         vectors++;
         if (obs_seg(w) !== 7'h7F) begin
            miscompares++; $display("FAIL reset_seg inst%0d: got %b want 1111111", w, obs_seg(w));
         end
         vectors++;
         if (obs_dig(w) !== 8'hFF) begin
            miscompares++; $display("FAIL reset_dig inst%0d: got %b want all ones", w, obs_dig(w));
         end
         vectors++;
         if (obs_done(w) !== 1'b0) begin
            miscompares++; $display("FAIL reset_done inst%0d: got %b want 0", w, obs_done(w));
         end
      end
      reset = 1'b0;
      wait_done(0, 100, cyc);
      vectors++;
      if (cyc != 11) begin
         miscompares++; $display("FAIL first_latency: got %0d cycles want 11", cyc);
      end
      push_frame(30, 4, 1'b0);
      capture(0, 4);
      for (int k = 0; k < 4; k++) begin
         e = exp_q.pop_front(); vectors++;
         if (obs_seg_arr[k] !== e) begin
            miscompares++; $display("FAIL val30 digit%0d: got %b want %b", k, obs_seg_arr[k], e);
         end
      end
   endtask

   task automatic test_blanking();
      int cyc;
      logic [6:0] e;
      blank_lz = 1'b1;
      push_frame(30, 4, 1'b1);
      capture(0, 4);
      for (int k = 0; k < 4; k++) begin
         e = exp_q.pop_front(); vectors++;
         if (obs_seg_arr[k] !== e) begin
            miscompares++; $display("FAIL blank30 digit%0d: got %b want %b", k, obs_seg_arr[k], e);
         end
      end
      corriente = 10'd0;
      wait_done(0, 100, cyc);
      wait_done(0, 100, cyc);
      push_frame(0, 4, 1'b1);
      capture(0, 4);
      for (int k = 0; k < 4; k++) begin
         e = exp_q.pop_front(); vectors++;
         if (obs_seg_arr[k] !== e) begin
            miscompares++; $display("FAIL blank0 digit%0d: got %b want %b", k, obs_seg_arr[k], e);
         end
      end
   endtask

   task automatic test_source_switch();
      int cyc;
      logic [6:0] e;
      blank_lz = 1'b0; control = 1'b1; frecuencia = 10'd1000;
      wait_done(0, 100, cyc);
      wait_done(0, 100, cyc);
      push_frame(1000, 4, 1'b0);
      capture(0, 4);
      for (int k = 0; k < 4; k++) begin
         e = exp_q.pop_front(); vectors++;
         if (obs_seg_arr[k] !== e) begin
            miscompares++; $display("FAIL freq1000 digit%0d: got %b want %b", k, obs_seg_arr[k], e);
         end
      end
      // The conversion in flight was sampled with control=1, so 1000 must persist once more.
      control = 1'b0; corriente = 10'd550;
      wait_done(0, 100, cyc);
      push_frame(1000, 4, 1'b0);
      capture(0, 4);
      for (int k = 0; k < 4; k++) begin
         e = exp_q.pop_front(); vectors++;
         if (obs_seg_arr[k] !== e) begin
            miscompares++; $display("FAIL hold1000 digit%0d: got %b want %b", k, obs_seg_arr[k], e);
         end
      end
      wait_done(0, 100, cyc);
      push_frame(550, 4, 1'b0);
      capture(0, 4);
      for (int k = 0; k < 4; k++) begin
         e = exp_q.pop_front(); vectors++;
         if (obs_seg_arr[k] !== e) begin
            miscompares++; $display("FAIL curr550 digit%0d: got %b want %b", k, obs_seg_arr[k], e);
         end
      end
   endtask

   task automatic test_back_to_back();
      int cyc;
      wait_done(0, 100, cyc);
      for (int n = 0; n < 3; n++) begin
         wait_done(0, 100, cyc);
         vectors++;
         if (cyc != 12) begin
            miscompares++; $display("FAIL b2b_interval%0d: got %0d cycles want 12", n, cyc);
         end
      end
   endtask

   task automatic test_overflow();
      int cyc;
      logic [6:0] e;
      control = 1'b0; corriente_w = 14'd10000; blank_lz = 1'b1;
      wait_done(1, 100, cyc);
      wait_done(1, 100, cyc);
      push_frame(10000, 4, 1'b1);
      capture(1, 4);
      for (int k = 0; k < 4; k++) begin
         e = exp_q.pop_front(); vectors++;
         if (obs_seg_arr[k] !== e) begin
            miscompares++; $display("FAIL ovf10000 digit%0d: got %b want %b", k, obs_seg_arr[k], e);
         end
      end
      corriente_w = 14'd9999; blank_lz = 1'b0;
      wait_done(1, 100, cyc);
      wait_done(1, 100, cyc);
      push_frame(9999, 4, 1'b0);
      capture(1, 4);
      for (int k = 0; k < 4; k++) begin
         e = exp_q.pop_front(); vectors++;
         if (obs_seg_arr[k] !== e) begin
            miscompares++; $display("FAIL val9999 digit%0d: got %b want %b", k, obs_seg_arr[k], e);
         end
      end
   endtask

   task automatic test_scan();
      logic [7:0] ed;
      logic       edone;
      reset = 1'b1;
      @(posedge clk_d); #1;
      reset = 1'b0;
      for (int k = 1; k <= 60; k++) begin
         exp_dig_q.push_back(~(8'h01 << (((k - 1) / 3) % 8)));
         edone = (k == 11) || (k == 35) || (k == 59);
         @(posedge clk_d); #1;
         ed = exp_dig_q.pop_front();
         vectors++;
         if (dig_s !== ed) begin
            miscompares++; $display("FAIL scan_dig cycle%0d: got %b want %b", k, dig_s, ed);
         end
         vectors++;
         if (done_s !== edone) begin
            miscompares++; $display("FAIL scan_done cycle%0d: got %b want %b", k, done_s, edone);
         end
      end
   endtask

   task automatic test_reset_abort();
      int cyc;
      logic [6:0] e;
      control = 1'b0; corriente = 10'd123; blank_lz = 1'b0;
      reset = 1'b1;
      @(posedge clk_d); #1;
      reset = 1'b0;
      repeat (5) begin
         @(posedge clk_d); #1;
         vectors++;
         if (done_a !== 1'b0) begin
            miscompares++; $display("FAIL abort_pre_done: got %b want 0", done_a);
         end
      end
      reset = 1'b1;
      @(posedge clk_d); #1;
      vectors++;
      if (seg_a !== 7'h7F) begin
         miscompares++; $display("FAIL abort_seg: got %b want 1111111", seg_a);
      end
      vectors++;
      if (dig_a !== 4'hF) begin
         miscompares++; $display("FAIL abort_dig: got %b want 1111", dig_a);
      end
      vectors++;
      if (done_a !== 1'b0) begin
         miscompares++; $display("FAIL abort_done: got %b want 0", done_a);
      end
      reset = 1'b0;
      push_frame(0, 4, 1'b0);
      capture(0, 4);
      for (int k = 0; k < 4; k++) begin
         e = exp_q.pop_front(); vectors++;
         if (obs_seg_arr[k] !== e) begin
            miscompares++; $display("FAIL abort_latch digit%0d: got %b want %b", k, obs_seg_arr[k], e);
         end
      end
      wait_done(0, 100, cyc);
      vectors++;
      if (cyc != 7) begin
         miscompares++; $display("FAIL abort_restart: got %0d more cycles want 7", cyc);
      end
      push_frame(123, 4, 1'b0);
      capture(0, 4);
      for (int k = 0; k < 4; k++) begin
         e = exp_q.pop_front(); vectors++;
         if (obs_seg_arr[k] !== e) begin
            miscompares++; $display("FAIL val123 digit%0d: got %b want %b", k, obs_seg_arr[k], e);
         end
      end
   endtask

   initial begin
      test_reset();
      test_blanking();
      test_source_switch();
      test_back_to_back();
      test_overflow();
      test_scan();
      test_reset_abort();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
